beat_decoder: RTL and testbench
===============================

BEAT_DECODER -- requirements
Module: beat_decoder

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth applied to each of bf_tick and bt_in (minimum 2).
REQ-002 Parameter: LOCK_COUNT, 2, number of consecutive identical measurements required to assert locked (range 1..15).
REQ-003 Port: clk_100mhz  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: bf_tick  input  1  base beat clock (e.g. 120 BPM square/pulse), asynchronous to clk_100mhz.
REQ-006 Port: bt_in  input  1  accent beat stream produced by the beat generator, asynchronous to clk_100mhz.
REQ-007 Port: period_out  output  8  last accepted measured period P, in base ticks.
REQ-008 Port: period_valid  output  1  one-cycle pulse when period_out is updated.
REQ-009 Port: locked  output  1  high while the accent period is stable.
REQ-010 Port: overflow  output  1  sticky flag: accent absent for more than 255 base ticks.

Function
REQ-011 The block SHALL pass bf_tick and bt_in through independent SYNC_STAGES-flop synchronizers, then detect rising edges (tick_e, acc_e), each a one-cycle pulse.
REQ-012 The block SHALL hold an 8-bit tick counter cnt and a state machine with states IDLE, ACQUIRE, MEASURE, LOCKED.
REQ-013 IDLE: entered on reset; the block SHALL transition to ACQUIRE on the first clock after reset release.
REQ-014 ACQUIRE: on acc_e, the block SHALL clear cnt and go to MEASURE; tick_e is ignored in this state.
REQ-015 MEASURE/LOCKED: each tick_e SHALL increment cnt by 1.
REQ-016 On acc_e in MEASURE/LOCKED, the block SHALL compute P = cnt + (tick_e ? 1 : 0), so a tick coincident with an accent counts toward the closing period.
REQ-017 If P = 0, the accent SHALL be discarded as a glitch: no update, cnt unchanged, state unchanged.
REQ-018 If P > 0: period_out <= P, period_valid pulses for one cycle, and cnt <= 0 in the same cycle.
REQ-019 A match counter SHALL increment when P equals the previous accepted P, saturating at LOCK_COUNT. It SHALL reload to 1 when P differs from the previous accepted P. It SHALL also reload to 1 on the first accepted P after ACQUIRE.
REQ-020 Transition MEASURE->LOCKED SHALL occur when the match counter reaches LOCK_COUNT. locked is asserted in the cycle after the qualifying period_valid.
REQ-021 In LOCKED, an accepted P differing from the previous P SHALL deassert locked next cycle and return to MEASURE, with match counter = 1.
REQ-022 If tick_e arrives while cnt = 255 and acc_e is not asserted in that cycle, the block SHALL set overflow, deassert locked, and go to ACQUIRE.
REQ-023 overflow SHALL remain high until the next accepted P (cleared in the same cycle period_valid pulses) or reset.
REQ-024 period_out SHALL hold its last value across ACQUIRE and overflow.
REQ-025 Latency: the period_valid pulse SHALL follow the bt_in rising edge by exactly SYNC_STAGES+1 clk_100mhz cycles.

Reset
REQ-026 While rst_n is low: state = IDLE, cnt = 0, match counter = 0, period_out = 0, period_valid = 0, locked = 0, overflow = 0, all synchronizer flops = 0.
REQ-027 Reset asserted mid-measurement SHALL abandon the measurement. No period_valid pulse SHALL be emitted on release.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=0, ACQUIRE=1, MEASURE=2, LOCKED=3), the 8-bit period width, and the 255 overflow limit.
REQ-029 One sub-module, beat_sync_edge, SHALL implement synchronizer plus rising-edge detect. It SHALL be instantiated twice.

Verification
REQ-030 Accents every 4 ticks, LOCK_COUNT=2 -> period_valid with P=4 at the 1st and 2nd accent after acquisition; locked rises one cycle after the 2nd.
REQ-031 Locked at P=4, then a single period of 6 -> period_out=6, locked falls next cycle, state MEASURE; two further 6s -> locked again.
REQ-032 Tick edge and accent edge in the same synchronized cycle with cnt=3 -> P=4 reported, cnt=0 afterwards.
REQ-033 Two accent edges with no tick between -> no period_valid, period_out unchanged, locked unchanged.
REQ-034 After one accepted P, send 256 ticks with no accent -> overflow=1 and locked=0 on the 256th tick. The next accent only re-acquires. The following accent after 5 ticks gives P=5 with overflow cleared.
REQ-035 rst_n pulsed low mid-period while locked -> all outputs 0 asynchronously; after release, the first accent only re-acquires.

Source files
------------

// File: rtl/beat_decoder_pkg.sv
// Shared encodings and limits for the beat decoder: FSM state, period width
// and the tick count at which a missing accent is declared.
package beat_decoder_pkg;
  localparam int PERIOD_W = 8;
  localparam logic [PERIOD_W-1:0] OVF_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;
endpackage

// File: rtl/beat_decoder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input followed by a
// rising-edge detector that produces a single-cycle pulse.
module beat_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/beat_decoder.sv
// Measures the accent period in base ticks, reports each accepted period,
// declares lock after LOCK_COUNT matching periods and flags a missing accent.
module beat_decoder
  import beat_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 2
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic                bf_tick,
  input  logic                bt_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                locked,
  output logic                overflow,
  output state_t              dbg_state
);
  localparam logic [3:0] LOCK_M = 4'(LOCK_COUNT);

  logic tick_e, acc_e;

  beat_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clk(clk_100mhz), .rst_n(rst_n), .async_in(bf_tick), .edge_o(tick_e)
  );
  beat_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_acc_sync (
    .clk(clk_100mhz), .rst_n(rst_n), .async_in(bt_in), .edge_o(acc_e)
  );

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [3:0]          match_q, match_d;
  logic                first_q, first_d;
  logic                pv_q, pv_d;
  logic                locked_q, locked_d;
  logic                ovf_q, ovf_d;

  logic                active, accept, ovf_evt;
  logic [PERIOD_W:0]   p_sum;
  logic [PERIOD_W-1:0] p_val;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      first_q  <= 1'b0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      match_q  <= match_d;
      first_q  <= first_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_ACQUIRE;
      ST_ACQUIRE: if (acc_e) state_d = ST_MEASURE;
      ST_MEASURE, ST_LOCKED: begin
        if (accept)       state_d = (match_d >= LOCK_M) ? ST_LOCKED : ST_MEASURE;
        else if (ovf_evt) state_d = ST_ACQUIRE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active  = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
    // A tick coincident with the accent closes the current period; a
    // 255+1 period cannot be represented and is clamped.
    p_sum   = {1'b0, cnt_q} + {{PERIOD_W{1'b0}}, tick_e};
    p_val   = p_sum[PERIOD_W] ? OVF_LIMIT : p_sum[PERIOD_W-1:0];
    accept  = active && acc_e && (p_val != '0);
    ovf_evt = active && tick_e && !acc_e && (cnt_q == OVF_LIMIT);

    match_d = match_q;
    if (accept) begin
      if (first_q || (p_val != period_q)) match_d = 4'd1;
      else if (match_q >= LOCK_M)         match_d = LOCK_M;
      else                                match_d = match_q + 4'd1;
    end

    cnt_d = cnt_q;
    if ((state_q == ST_ACQUIRE) && acc_e)    cnt_d = '0;
    else if (accept)                         cnt_d = '0;
    else if (active && tick_e && !ovf_evt)   cnt_d = cnt_q + 8'd1;

    first_d = first_q;
    if ((state_q == ST_ACQUIRE) && acc_e) first_d = 1'b1;
    else if (accept)                      first_d = 1'b0;

    period_d = accept ? p_val : period_q;
    pv_d     = accept;
    ovf_d    = accept ? 1'b0 : (ovf_evt ? 1'b1 : ovf_q);
    locked_d = (state_q == ST_LOCKED) && !ovf_evt;
  end

  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign overflow     = ovf_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_beat_decoder.sv
// Directed bench for beat_decoder: acquisition, lock, period change,
// coincident edges, glitch accents, overflow and mid-period reset.
module tb_beat_decoder;
  import beat_decoder_pkg::*;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       bf_tick = 1'b0;
  logic       bt_in = 1'b0;
  logic [7:0] period_out;
  logic       period_valid;
  logic       locked;
  logic       overflow;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  beat_decoder #(.SYNC_STAGES(2), .LOCK_COUNT(2)) dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .bf_tick(bf_tick), .bt_in(bt_in),
    .period_out(period_out), .period_valid(period_valid), .locked(locked),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk_100mhz = ~clk_100mhz;
  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // event monitor, sampled on the falling edge
  int   pv_cnt = 0, pv_cyc = -1, lk_rise_cyc = -1, lk_fall_cyc = -1, acc_cyc = 0;
  logic [7:0] pv_period = 8'd0;
  logic pv_ovf = 1'b0, lk_prev = 1'b0;
  always @(negedge clk_100mhz) begin
    if (period_valid) begin
      pv_cnt++;
      pv_cyc = cyc;
      pv_period = period_out;
      pv_ovf = overflow;
    end
    if (locked && !lk_prev) lk_rise_cyc = cyc;
    if (!locked && lk_prev) lk_fall_cyc = cyc;
    lk_prev = locked;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic t, input logic a);
    @(negedge clk_100mhz);
    if (a) acc_cyc = cyc;
    bf_tick = t;
    bt_in   = a;
    repeat (4) @(negedge clk_100mhz);
    bf_tick = 1'b0;
    bt_in   = 1'b0;
    repeat (4) @(negedge clk_100mhz);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  task automatic accent();
    drive(1'b0, 1'b1);
  endtask

  int base;

  initial begin
    // reset state
    repeat (3) @(negedge clk_100mhz);
    check("rst_period", period_out, 0);
    check("rst_pv", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    check("acq_state", dbg_state, ST_ACQUIRE);

    // acquisition then two periods of 4 -> lock
    base = pv_cnt;
    accent();
    check("acq_no_pv", pv_cnt, base);
    check("meas_state", dbg_state, ST_MEASURE);
    ticks(4); accent();
    check("p4a_pv", pv_cnt, base + 1);
    check("p4a_period", pv_period, 4);
    check("p4a_latency", pv_cyc - acc_cyc, 3);
    check("p4a_unlocked", locked, 0);
    ticks(4); accent();
    check("p4b_pv", pv_cnt, base + 2);
    check("p4b_period", pv_period, 4);
    check("p4b_locked", locked, 1);
    check("p4b_lock_delay", lk_rise_cyc - pv_cyc, 1);
    check("p4b_state", dbg_state, ST_LOCKED);

    // one period of 6 breaks lock, further 6s relock
    ticks(6); accent();
    check("p6_period", period_out, 6);
    check("p6_unlock_delay", lk_fall_cyc - pv_cyc, 1);
    check("p6_state", dbg_state, ST_MEASURE);
    ticks(6); accent();
    ticks(6); accent();
    check("p6_relocked", locked, 1);
    check("p6_period2", period_out, 6);

    // tick coincident with accent closes a period of 3+1
    base = pv_cnt;
    ticks(3); drive(1'b1, 1'b1);
    check("coin_pv", pv_cnt, base + 1);
    check("coin_period", pv_period, 4);
    ticks(4); accent();
    check("coin_cnt_cleared", pv_period, 4);
    check("coin_relocked", locked, 1);

    // two accents without a tick between are discarded
    base = pv_cnt;
    accent(); accent();
    check("glitch_no_pv", pv_cnt, base);
    check("glitch_period", period_out, 4);
    check("glitch_locked", locked, 1);
    check("glitch_state", dbg_state, ST_LOCKED);

    // 256 ticks without an accent -> overflow
    ticks(255);
    check("ovf_255_clear", overflow, 0);
    check("ovf_255_locked", locked, 1);
    ticks(1);
    check("ovf_set", overflow, 1);
    check("ovf_unlocked", locked, 0);
    check("ovf_state", dbg_state, ST_ACQUIRE);
    check("ovf_period_held", period_out, 4);
    base = pv_cnt;
    accent();
    check("ovf_reacq_no_pv", pv_cnt, base);
    check("ovf_still_set", overflow, 1);
    ticks(5); accent();
    check("ovf_p5_pv", pv_cnt, base + 1);
    check("ovf_p5_period", pv_period, 5);
    check("ovf_clear_with_pv", pv_ovf, 0);
    check("ovf_cleared", overflow, 0);

    // lock again, then reset mid-period
    ticks(5); accent();
    check("pre_rst_locked", locked, 1);
    ticks(2);
    @(posedge clk_100mhz);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", period_out, 0);
    check("arst_locked", locked, 0);
    check("arst_ovf", overflow, 0);
    check("arst_pv", period_valid, 0);
    check("arst_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk_100mhz);
    base = pv_cnt;
    rst_n = 1'b1;
    repeat (4) @(negedge clk_100mhz);
    check("post_rst_no_pv", pv_cnt, base);
    check("post_rst_state", dbg_state, ST_ACQUIRE);
    ticks(3); accent();
    check("post_rst_acq_no_pv", pv_cnt, base);
    check("post_rst_meas", dbg_state, ST_MEASURE);
    ticks(4); accent();
    check("post_rst_pv", pv_cnt, base + 1);
    check("post_rst_period", pv_period, 4);
    check("post_rst_unlocked", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got 1 expected 0");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
